// File: rtl/seq_control_unit_if.sv
// Handshake/status bundle between the sequencing controller and its datapath/memory.
interface seq_control_unit_if #(
    parameter int unsigned DATA_W = 32
);
    logic              stop;
    logic [DATA_W-1:0] IR_reg;
    logic              mem_ready;
    logic [2:0]        state;
    logic [2:0]        step;
    logic [3:0]        opclass;
    logic              mem_read;
    logic              mem_write;
    logic              IRin;
    logic              run;
    logic              clear;
    logic              done;

    modport master (
        input  stop, IR_reg, mem_ready,
        output state, step, opclass, mem_read, mem_write, IRin, run, clear, done
    );

    modport slave (
        output stop, IR_reg, mem_ready,
        input  state, step, opclass, mem_read, mem_write, IRin, run, clear, done
    );
endinterface

// File: rtl/seq_control_unit.sv
// Instruction sequencing FSM: fetch (T0-T2) then a class-dependent number of EXEC T-steps.
// Optional macro SEQ_WAIT_EN stretches memory-strobe cycles until mem_ready.
module seq_control_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OPC_W  = 5
) (
    input logic                clock,
    input logic                reset,
    seq_control_unit_if.master bus
);

    typedef enum logic [2:0] {
        StReset  = 3'd0,
        StFetch0 = 3'd1,
        StFetch1 = 3'd2,
        StFetch2 = 3'd3,
        StExec   = 3'd4,
        StPause  = 3'd5,
        StHalt   = 3'd6
    } state_e;

    // Class codes as seen on opclass; 0 means nothing latched since reset.
    typedef enum logic [3:0] {
        ClsNone   = 4'd0,
        ClsLd     = 4'd1,
        ClsSt     = 4'd2,
        ClsAlu3   = 4'd3,
        ClsMulDiv = 4'd4,
        ClsUnary  = 4'd5,
        ClsBr     = 4'd6,
        ClsJal    = 4'd7,
        ClsIn     = 4'd8,
        ClsSingle = 4'd9,
        ClsHalt   = 4'd10
    } cls_e;

    function automatic cls_e decode(input logic [31:0] opc);
        cls_e c;
        case (opc) inside
            0:               c = ClsLd;
            2:               c = ClsSt;
            1, [3:14]:       c = ClsAlu3;
            15, 16:          c = ClsMulDiv;
            17, 18:          c = ClsUnary;
            19:              c = ClsBr;
            21:              c = ClsJal;
            22:              c = ClsIn;
            27:              c = ClsHalt;
            default:         c = ClsSingle;
        endcase
        return c;
    endfunction

    // Final EXEC T-step: 3 + step_count - 1.
    function automatic logic [2:0] last_step(input cls_e c);
        logic [2:0] s;
        unique case (c)
            ClsLd:                     s = 3'd7;
            ClsSt, ClsMulDiv, ClsBr:   s = 3'd6;
            ClsAlu3, ClsJal:           s = 3'd5;
            ClsUnary, ClsIn:           s = 3'd4;
            default:                   s = 3'd3;
        endcase
        return s;
    endfunction

    state_e     state_q, state_d;
    logic [2:0] step_q, step_d;
    cls_e       opclass_q, opclass_d;

    logic [OPC_W-1:0] opc;
    logic             mem_ok;
    logic [2:0]       step_out;
    logic             rd, wr, irin, run, clr, dn;

    assign opc = bus.IR_reg[DATA_W-1 -: OPC_W];

`ifdef SEQ_WAIT_EN
    assign mem_ok = bus.mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        opclass_d = opclass_q;
        step_out  = 3'd0;
        rd        = 1'b0;
        wr        = 1'b0;
        irin      = 1'b0;
        run       = 1'b0;
        clr       = 1'b0;
        dn        = 1'b0;
        unique case (state_q)
            StReset: begin
                clr     = 1'b1;
                state_d = StFetch0;
            end
            StFetch0: begin
                run     = 1'b1;
                state_d = StFetch1;
            end
            StFetch1: begin
                run      = 1'b1;
                step_out = 3'd1;
                rd       = 1'b1;
                if (mem_ok) state_d = StFetch2;
            end
            StFetch2: begin
                run       = 1'b1;
                step_out  = 3'd2;
                irin      = 1'b1;
                state_d   = StExec;
                step_d    = 3'd3;
                opclass_d = decode(32'(opc));
            end
            StExec: begin
                run      = 1'b1;
                step_out = step_q;
                rd       = (opclass_q == ClsLd) && (step_q == 3'd5);
                wr       = (opclass_q == ClsSt) && (step_q == 3'd6);
                // A stalled strobe holds everything, including a pending done.
                if (!((rd || wr) && !mem_ok)) begin
                    if (step_q == last_step(opclass_q)) begin
                        dn = 1'b1;
                        if (opclass_q == ClsHalt) state_d = StHalt;
                        else if (bus.stop)        state_d = StPause;
                        else                      state_d = StFetch0;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end
            StPause: begin
                if (!bus.stop) state_d = StFetch0;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StReset;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StReset;
            step_q    <= 3'd0;
            opclass_q <= ClsNone;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            opclass_q <= opclass_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.step      = step_out;
    assign bus.opclass   = opclass_q;
    assign bus.mem_read  = rd;
    assign bus.mem_write = wr;
    assign bus.IRin      = irin;
    assign bus.run       = run;
    assign bus.clear     = clr;
    assign bus.done      = dn;

endmodule

// File: tb/tb_seq_control_unit.sv
// Directed bench for seq_control_unit: cycle-by-cycle expected status vectors.
module tb_seq_control_unit;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    seq_control_unit_if #(.DATA_W(32)) bus ();

    seq_control_unit #(
        .DATA_W(32),
        .OPC_W (5)
    ) dut (
        .clock(clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {state, step, mem_read, mem_write, IRin, run, clear, done}
    logic [11:0] obs_vec;
    assign obs_vec = {bus.state, bus.step, bus.mem_read, bus.mem_write, bus.IRin,
                      bus.run, bus.clear, bus.done};

    function automatic logic [11:0] pk(input int st, input int stp, input bit mr, input bit mw,
                                       input bit ir, input bit rn, input bit cl, input bit dn);
        return {3'(st), 3'(stp), mr, mw, ir, rn, cl, dn};
    endfunction

    function automatic logic [11:0] ex(input int stp, input bit mr, input bit mw, input bit dn);
        return pk(4, stp, mr, mw, 1'b0, 1'b1, 1'b0, dn);
    endfunction

    localparam logic [11:0] VRst   = 12'b000_000_000010;
    localparam logic [11:0] VF0    = 12'b001_000_000100;
    localparam logic [11:0] VF1    = 12'b010_001_100100;
    localparam logic [11:0] VF2    = 12'b011_010_001100;
    localparam logic [11:0] VPause = 12'b101_000_000000;
    localparam logic [11:0] VHalt  = 12'b110_000_000000;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag, input logic [11:0] exp);
        check_eq(tag, 32'(obs_vec), 32'(exp));
        tick();
    endtask

    task automatic fetch(input string tag);
        cyc({tag, "_f0"}, VF0);
        cyc({tag, "_f1"}, VF1);
        cyc({tag, "_f2"}, VF2);
    endtask

    task automatic set_op(input logic [4:0] op);
        bus.IR_reg = {op, 27'h5a5a5a5};
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.stop      = 1'b0;
        bus.mem_ready = 1'b1;
        set_op(5'b00011);
        tick();
        check_eq("rst_vec", 32'(obs_vec), 32'(VRst));
        check_eq("rst_opclass", 32'(bus.opclass), 32'd0);
        reset = 1'b0;
        tick();

        // ADD: three EXEC steps, FETCH0 again six cycles later
        fetch("add");
        check_eq("add_opclass", 32'(bus.opclass), 32'd3);
        cyc("add_s3", ex(3, 0, 0, 0));
        cyc("add_s4", ex(4, 0, 0, 0));
        cyc("add_s5", ex(5, 0, 0, 1));

        // LD: five EXEC steps with a data read at step 5
        set_op(5'b00000);
`ifdef SEQ_WAIT_EN
        cyc("ld_f0", VF0);
        bus.mem_ready = 1'b0;
        cyc("ld_f1a", VF1);
        cyc("ld_f1b", VF1);
        bus.mem_ready = 1'b1;
        cyc("ld_f1c", VF1);
        cyc("ld_f2", VF2);
        cyc("ld_s3", ex(3, 0, 0, 0));
        cyc("ld_s4", ex(4, 0, 0, 0));
        bus.mem_ready = 1'b0;
        cyc("ld_s5a", ex(5, 1, 0, 0));
        cyc("ld_s5b", ex(5, 1, 0, 0));
        cyc("ld_s5c", ex(5, 1, 0, 0));
        bus.mem_ready = 1'b1;
        cyc("ld_s5d", ex(5, 1, 0, 0));
`else
        bus.mem_ready = 1'b0;
        fetch("ld");
        cyc("ld_s3", ex(3, 0, 0, 0));
        cyc("ld_s4", ex(4, 0, 0, 0));
        cyc("ld_s5", ex(5, 1, 0, 0));
`endif
        check_eq("ld_opclass", 32'(bus.opclass), 32'd1);
        cyc("ld_s6", ex(6, 0, 0, 0));
        cyc("ld_s7", ex(7, 0, 0, 1));
        bus.mem_ready = 1'b1;

        // ST interrupted by reset while mem_write is high
        set_op(5'b00010);
        fetch("st");
        cyc("st_s3", ex(3, 0, 0, 0));
        cyc("st_s4", ex(4, 0, 0, 0));
        cyc("st_s5", ex(5, 0, 0, 0));
`ifdef SEQ_WAIT_EN
        bus.mem_ready = 1'b0;
        reset = 1'b1;
        cyc("st_s6", ex(6, 0, 1, 0));
`else
        reset = 1'b1;
        cyc("st_s6", ex(6, 0, 1, 1));
`endif
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        check_eq("st_rst_opclass", 32'(bus.opclass), 32'd0);
        cyc("st_rst", VRst);

        // MUL with stop raised mid-instruction
        set_op(5'b01111);
        fetch("mul");
        check_eq("mul_opclass", 32'(bus.opclass), 32'd4);
        cyc("mul_s3", ex(3, 0, 0, 0));
        bus.stop = 1'b1;
        cyc("mul_s4", ex(4, 0, 0, 0));
        cyc("mul_s5", ex(5, 0, 0, 0));
        cyc("mul_s6", ex(6, 0, 0, 1));
        cyc("mul_pause_a", VPause);
        cyc("mul_pause_b", VPause);
        bus.stop = 1'b0;
        cyc("mul_pause_c", VPause);

        // Undefined opcode decodes as SINGLE
        set_op(5'b11111);
        fetch("sgl");
        check_eq("sgl_opclass", 32'(bus.opclass), 32'd9);
        cyc("sgl_s3", ex(3, 0, 0, 1));

        // HALT is terminal, stop/mem_ready ignored
        set_op(5'b11011);
        fetch("hlt");
        check_eq("hlt_opclass", 32'(bus.opclass), 32'd10);
        cyc("hlt_s3", ex(3, 0, 0, 1));
        for (int i = 0; i < 20; i++) begin
            bus.stop      = i[0];
            bus.mem_ready = i[1];
            cyc("hlt_hold", VHalt);
        end
        bus.stop      = 1'b0;
        bus.mem_ready = 1'b1;
        reset = 1'b1;
        tick();
        check_eq("hlt_rst_vec", 32'(obs_vec), 32'(VRst));
        check_eq("hlt_rst_opclass", 32'(bus.opclass), 32'd0);
        reset = 1'b0;
        tick();
        cyc("post_rst_f0", VF0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_control_unit.md
SEQ_CONTROL_UNIT -- requirements
Module: seq_control_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; parameters (name, default, meaning) follow.
REQ-002 DATA_W, 32, instruction register width.
REQ-003 OPC_W, 5, opcode field width; the field occupies IR_reg[DATA_W-1 : DATA_W-OPC_W].
REQ-004 clock  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 stop  in  1  pause request, sampled at instruction boundary.
REQ-007 IR_reg  in  DATA_W  current instruction register contents.
REQ-008 mem_ready  in  1  memory access complete this cycle.
REQ-009 state  out  3  encoded FSM state: RESET=0, FETCH0=1, FETCH1=2, FETCH2=3, EXEC=4, PAUSE=5, HALT=6.
REQ-010 step  out  3  T-step index: 0-2 in fetch, 3-7 in EXEC, 0 otherwise.
REQ-011 opclass  out  4  latched instruction class (REQ-016).
REQ-012 mem_read, mem_write, IRin  out  1 each  memory strobes and IR load enable.
REQ-013 run, clear, done  out  1 each  running flag, reset-phase clear, one-cycle instruction-complete pulse.

Function
REQ-014 Transitions: RESET->FETCH0; FETCH0->FETCH1; FETCH1->FETCH2 when the memory read completes; FETCH2->EXEC at step 3.
REQ-015 FETCH1 SHALL assert mem_read; FETCH2 SHALL assert IRin; opclass SHALL be latched from IR_reg on the FETCH2->EXEC edge.
REQ-016 Class / EXEC step count: LD(00000)=5; ST(00010)=4; ALU3 (00001, 00011-01110)=3; MULDIV (01111, 10000)=4; UNARY (10001, 10010)=2; BR(10011)=4; JAL(10101)=3; IN(10110)=2; SINGLE (10100, 10111-11010)=1; HALT(11011)=1; any other opcode SHALL decode as SINGLE.
REQ-017 In EXEC, step SHALL increment by one per cycle from 3; on the last step, done SHALL pulse for exactly that cycle.
REQ-018 LD SHALL assert mem_read at step 5; ST SHALL assert mem_write at step 6; at most one of mem_read/mem_write SHALL be high in any cycle.
REQ-019 After the last EXEC step: HALT class->HALT; else stop=1->PAUSE; else->FETCH0.
REQ-020 PAUSE SHALL return to FETCH0 in the first cycle stop=0; stop SHALL NOT affect an instruction in progress.
REQ-021 HALT SHALL be terminal until reset; stop and mem_ready SHALL be ignored there.
REQ-022 run SHALL be 1 in FETCH0-EXEC and 0 in RESET, PAUSE and HALT; clear SHALL be 1 only in RESET.
REQ-023 step SHALL never exceed 7; the step counter SHALL reset to 3 on each EXEC entry.

Reset
REQ-024 reset=1 at a rising edge SHALL force state=RESET, step=0, opclass=0, all strobes and done=0, run=0, clear=1, from any state including mid-EXEC and wait cycles.
REQ-025 The first cycle after reset deasserts SHALL be RESET, then FETCH0.

Configuration
REQ-026 Macro SEQ_WAIT_EN: when defined, every memory-strobe cycle (FETCH1, LD step 5, ST step 6) SHALL hold state, step and strobe until mem_ready=1, with no cycle limit.
REQ-027 Without SEQ_WAIT_EN, every memory strobe cycle SHALL last exactly one cycle and mem_ready SHALL be ignored.

Verification
REQ-028 Reset, IR_reg opcode 00011 (ADD), mem_ready=1 -> FETCH0,1,2, EXEC steps 3-5, done at step 5, FETCH0 six cycles after the first FETCH0.
REQ-029 SEQ_WAIT_EN, LD opcode, mem_ready low 2 cycles in FETCH1 and 3 cycles at step 5 -> mem_read held 3 then 4 cycles; done at step 7; 13 cycles total from FETCH0.
REQ-030 stop=1 raised at MUL step 4 -> steps 5-6 complete, done at step 6, PAUSE with run=0; stop=0 -> FETCH0 next cycle.
REQ-031 Opcode 11111 -> SINGLE class, one EXEC step (step 3), done, FETCH0.
REQ-032 HALT opcode 11011 -> HALT after step 3, run=0 held 20 cycles despite stop toggling; reset -> RESET, clear=1.
REQ-033 reset asserted at ST step 6 while mem_write high -> next cycle state=RESET, mem_write=0, step=0.
